mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 74 +++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory read/write ports served by mem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_port_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [14:0] c_addr;
    logic [15:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [15:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [14:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;

    logic [14:0] m_raddr;
    logic [15:0] m_rdata;
    logic        m_wen;
    logic [14:0] m_waddr;
    logic [15:0] m_wdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_raddr, m_wen, m_waddr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_raddr, m_wen, m_waddr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto one memory read port and one write port, CPU-first with
// a starvation escape for the secondary requester and an owner-tagged read-return pipeline.
module mem_port_arbiter #(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    logic [3:0]        wait_cnt;
    logic              d_prio;
    logic              c_win;
    logic              d_win;
    logic              granted;
    logic              sel_we;
    logic [14:0]       sel_addr;
    logic [15:0]       sel_wdata;
    logic              rd_issue;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;

    // Grants are suppressed while reset is held so nothing is issued into a clearing pipeline.
    always_comb begin
        d_prio    = bus.d_req && (wait_cnt == 4'(MAX_WAIT));
        d_win     = !reset && bus.d_req && (d_prio || !bus.c_req);
        c_win     = !reset && bus.c_req && !d_win;
        granted   = c_win || d_win;
        sel_we    = d_win ? bus.d_we    : bus.c_we;
        sel_addr  = d_win ? bus.d_addr  : bus.c_addr;
        sel_wdata = d_win ? bus.d_wdata : bus.c_wdata;
        rd_issue  = granted && !sel_we;
    end

    assign bus.c_gnt   = c_win;
    assign bus.d_gnt   = d_win;
    assign bus.m_wen   = granted && sel_we;
    assign bus.m_raddr = rd_issue ? sel_addr : 15'd0;
    assign bus.m_waddr = (granted && sel_we) ? sel_addr  : 15'd0;
    assign bus.m_wdata = (granted && sel_we) ? sel_wdata : 16'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (bus.d_req && !d_win) begin
            if (wait_cnt != 4'(MAX_WAIT))
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Owner bit is 1 for the secondary requester; the tag travels with the read so returns need no lookup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            pipe_valid[0] <= rd_issue;
            pipe_owner[0] <= d_win;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_owner[i] <= pipe_owner[i-1];
            end
        end
    end

    assign bus.c_rvalid = pipe_valid[RD_LAT-1] && !pipe_owner[RD_LAT-1];
    assign bus.d_rvalid = pipe_valid[RD_LAT-1] &&  pipe_owner[RD_LAT-1];
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter, checked every cycle against a
// transaction-level model (grant rules, starvation count, queue of outstanding reads).
module tb_mem_port_arbiter;
    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    typedef enum int {P_CGNT, P_DGNT, P_CRV, P_DRV, P_CRDATA, P_DRDATA,
                      P_RADDR, P_WEN, P_WADDR, P_WDATA} pin_sig_e;
    typedef struct { int due; logic owner; logic [14:0] addr; } rd_t;
    typedef struct { int cyc; pin_sig_e sig; logic [15:0] val; string name; } pin_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_port_arbiter_if bif();

    mem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   m_wait = 0;
    logic c_gnt_q = 1'b0;
    logic d_gnt_q = 1'b0;
    rd_t  rd_q[$];
    pin_t pins[$];

    logic [15:0] rd_pipe [RD_LAT];
    logic        e_cg, e_dg, e_crv, e_drv, e_we;
    logic [14:0] e_addr;
    logic [15:0] e_wdata, e_rdata;

    function automatic logic [15:0] word(input logic [14:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // Memory model: the read port returns word(addr) RD_LAT cycles after the address.
    always @(posedge clk) begin
        rd_pipe[0] <= word(bif.m_raddr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bif.m_rdata = rd_pipe[RD_LAT-1];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] pin_value(input pin_sig_e s);
        case (s)
            P_CGNT:   return 16'(bif.c_gnt);
            P_DGNT:   return 16'(bif.d_gnt);
            P_CRV:    return 16'(bif.c_rvalid);
            P_DRV:    return 16'(bif.d_rvalid);
            P_CRDATA: return bif.c_rdata;
            P_DRDATA: return bif.d_rdata;
            P_RADDR:  return 16'(bif.m_raddr);
            P_WEN:    return 16'(bif.m_wen);
            P_WADDR:  return 16'(bif.m_waddr);
            default:  return bif.m_wdata;
        endcase
    endfunction

    task automatic pin(input int d, input pin_sig_e s, input logic [15:0] v, input string name);
        pins.push_back('{cyc + d, s, v, name});
    endtask

    // Compare process: predict this cycle from the model, check, then advance the model over the edge.
    always @(negedge clk) begin
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (reset) begin
            rd_q.delete();
            m_wait = 0;
        end else begin
            e_dg = bif.d_req && ((m_wait == MAX_WAIT) || !bif.c_req);
            e_cg = bif.c_req && !e_dg;
        end
        e_crv = 1'b0;
        e_drv = 1'b0;
        e_rdata = 16'd0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e_crv   = !rd_q[0].owner;
            e_drv   =  rd_q[0].owner;
            e_rdata = word(rd_q[0].addr);
            void'(rd_q.pop_front());
        end
        e_we    = e_dg ? bif.d_we    : bif.c_we;
        e_addr  = e_dg ? bif.d_addr  : bif.c_addr;
        e_wdata = e_dg ? bif.d_wdata : bif.c_wdata;

        checkOutput("c_gnt",    16'(bif.c_gnt),    16'(e_cg));
        checkOutput("d_gnt",    16'(bif.d_gnt),    16'(e_dg));
        checkOutput("c_rvalid", 16'(bif.c_rvalid), 16'(e_crv));
        checkOutput("d_rvalid", 16'(bif.d_rvalid), 16'(e_drv));
        if (e_cg || e_dg) begin
            checkOutput("m_wen", 16'(bif.m_wen), 16'(e_we));
            if (e_we) begin
                checkOutput("m_waddr", 16'(bif.m_waddr), 16'(e_addr));
                checkOutput("m_wdata", bif.m_wdata, e_wdata);
            end else begin
                checkOutput("m_raddr", 16'(bif.m_raddr), 16'(e_addr));
                rd_q.push_back('{cyc + RD_LAT, e_dg, e_addr});
            end
        end else begin
            checkOutput("m_wen_idle",   16'(bif.m_wen),   16'd0);
            checkOutput("m_raddr_idle", 16'(bif.m_raddr), 16'd0);
            checkOutput("m_waddr_idle", 16'(bif.m_waddr), 16'd0);
            checkOutput("m_wdata_idle", bif.m_wdata,      16'd0);
        end
        if (e_crv) checkOutput("c_rdata", bif.c_rdata, e_rdata);
        if (e_drv) checkOutput("d_rdata", bif.d_rdata, e_rdata);

        foreach (pins[i])
            if (pins[i].cyc == cyc) checkOutput(pins[i].name, pin_value(pins[i].sig), pins[i].val);

        if (!reset) begin
            if (bif.d_req && !e_dg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else                    m_wait = 0;
        end
        c_gnt_q = bif.c_gnt;
        d_gnt_q = bif.d_gnt;
        cyc++;
    end

    task automatic applyStimulus(input logic rst,
                                 input logic cr, input logic cw, input logic [14:0] ca, input logic [15:0] cd,
                                 input logic dr, input logic dw, input logic [14:0] da, input logic [15:0] dd);
        @(posedge clk);
        #1;
        reset       = rst;
        bif.c_req   = cr;
        bif.c_we    = cw;
        bif.c_addr  = ca;
        bif.c_wdata = cd;
        bif.d_req   = dr;
        bif.d_we    = dw;
        bif.d_addr  = da;
        bif.d_wdata = dd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Each requester holds its request until granted, then issues a new one with probability pct.
    task automatic runTraffic(input int n, input int c_pct, input int d_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (!bif.c_req || c_gnt_q) begin
                bif.c_req   = ($urandom_range(99) < c_pct);
                bif.c_we    = 1'($urandom_range(1));
                bif.c_addr  = 15'($urandom);
                bif.c_wdata = 16'($urandom);
            end
            if (!bif.d_req || d_gnt_q) begin
                bif.d_req   = ($urandom_range(99) < d_pct);
                bif.d_we    = 1'($urandom_range(1));
                bif.d_addr  = 15'($urandom);
                bif.d_wdata = 16'($urandom);
            end
        end
    endtask

    initial begin
        bif.c_req = 0; bif.c_we = 0; bif.c_addr = 0; bif.c_wdata = 0;
        bif.d_req = 0; bif.d_we = 0; bif.d_addr = 0; bif.d_wdata = 0;

        applyStimulus(1, 1, 0, 15'h0010, 0, 1, 0, 15'h0033, 0);
        pin(0, P_CGNT, 0, "gnt_in_reset");
        applyStimulus(1, 1, 0, 15'h0010, 0, 0, 0, 0, 0);
        pin(0, P_CRV, 0, "rvalid_in_reset");

        applyStimulus(0, 1, 0, 15'h0010, 0, 0, 0, 0, 0);
        pin(0, P_CGNT,   1,          "first_grant_after_reset");
        pin(0, P_RADDR,  16'h0010,   "load_raddr");
        pin(1, P_CRV,    0,          "load_not_early");
        pin(2, P_CRV,    1,          "load_rvalid");
        pin(2, P_CRDATA, 16'h10EF,   "load_rdata");
        applyStimulus(0, 1, 1, 15'h0020, 16'hBEEF, 0, 0, 0, 0);
        pin(0, P_WEN,   1,           "store_wen");
        pin(0, P_WADDR, 16'h0020,    "store_waddr");
        pin(0, P_WDATA, 16'hBEEF,    "store_wdata");
        pin(1, P_WEN,   0,           "store_one_cycle");
        pin(2, P_CRV,   0,           "store_no_rvalid");
        idle(12);
        pin(0, P_CGNT, 0, "idle_c_gnt");
        pin(0, P_WEN,  0, "idle_wen");

        for (int k = 0; k < 15; k++)
            pin(1 + k, (k % 5 == 4) ? P_DGNT : P_CGNT, 1, "starve_pattern");
        pin(1, P_DGNT, 0, "starve_d_denied");
        runTraffic(15, 100, 100);
        runTraffic(8, 0, 0);
        idle(3);

        applyStimulus(0, 1, 0, 15'h0001, 0, 0, 0, 0, 0);
        pin(0, P_CGNT,   1,        "alt_c1_gnt");
        pin(2, P_CRV,    1,        "alt_c1_rvalid");
        pin(2, P_CRDATA, 16'h01FE, "alt_c1_rdata");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 15'h0002, 0);
        pin(0, P_DGNT,   1,        "alt_d2_gnt");
        pin(2, P_DRV,    1,        "alt_d2_rvalid");
        pin(2, P_CRV,    0,        "alt_d2_not_c");
        pin(2, P_DRDATA, 16'h02FD, "alt_d2_rdata");
        applyStimulus(0, 1, 0, 15'h0003, 0, 0, 0, 0, 0);
        pin(2, P_CRV,    1,        "alt_c3_rvalid");
        pin(2, P_CRDATA, 16'h03FC, "alt_c3_rdata");
        idle(4);

        applyStimulus(0, 0, 0, 0, 0, 1, 0, 15'h0005, 0);
        pin(0, P_DGNT, 1, "flush_d_gnt");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pin(1, P_DRV, 0, "flushed_read_dropped");
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 15'h0004, 0);
        pin(0, P_DGNT, 0, "d_gnt_in_reset");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 15'h0004, 0);
        pin(0, P_DGNT,   1,        "post_reset_d_gnt");
        pin(2, P_DRV,    1,        "post_reset_d_rvalid");
        pin(2, P_DRDATA, 16'h04FB, "post_reset_d_rdata");
        idle(4);

        runTraffic(3000, 70, 60);
        runTraffic(8, 0, 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
